// File: rtl/adder8_stim_checker.sv
// LFSR-driven stimulus generator and response checker for an 8-bit registered adder.
// Vectors go out in RUN; sums come back LATENCY cycles later and are checked against a delay line.
module adder8_stim_checker #(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [23:0] SEED        = 24'hACE15A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  A_out,
    output logic [7:0]  B_out,
    output logic        Cin_out,
    input  logic [7:0]  SUM_in,
    input  logic        Cout_in,
    output logic        busy,
    output logic        done,
    output logic        mismatch,
    output logic [15:0] vec_count,
    output logic [15:0] err_count
);

    localparam logic [15:0] NumVec    = 16'(NUM_VECTORS);
    localparam logic [3:0]  DrainLast = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e      r_state;
    logic [23:0] r_lfsr;
    logic [15:0] r_vec_count;
    logic [15:0] r_err_count;
    logic        r_mismatch;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_drain_cnt;

    logic [LATENCY-1:0] r_dl_valid;
    logic [8:0]         r_dl_ref [LATENCY];

    logic        w_run;
    logic [23:0] w_lfsr_next;
    logic [8:0]  w_ref;
    logic        w_cmp_fail;

    // Fibonacci taps 24,23,22,17 (1-based), shifting towards the MSB.
    assign w_lfsr_next = {r_lfsr[22:0], r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16]};

    assign w_run   = (r_state == StRun);
    assign A_out   = w_run ? r_lfsr[7:0]  : 8'h00;
    assign B_out   = w_run ? r_lfsr[15:8] : 8'h00;
    assign Cin_out = w_run ? r_lfsr[16]   : 1'b0;

    assign w_ref      = {1'b0, A_out} + {1'b0, B_out} + {8'h00, Cin_out};
    assign w_cmp_fail = r_dl_valid[LATENCY-1] && ({Cout_in, SUM_in} != r_dl_ref[LATENCY-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_lfsr      <= SEED;
            r_vec_count <= 16'h0000;
            r_err_count <= 16'h0000;
            r_mismatch  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= 4'h0;
        end else begin
            r_mismatch <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_lfsr      <= SEED;
                        r_vec_count <= 16'h0000;
                        r_err_count <= 16'h0000;
                        if (NumVec == 16'h0000) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StRun;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    r_lfsr      <= w_lfsr_next;
                    r_vec_count <= r_vec_count + 16'h0001;
                    if (r_vec_count == NumVec - 16'h0001) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= DrainLast;
                    end
                end
                StDrain: begin
                    if (r_drain_cnt == 4'h0) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'h1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // Compares only occur in RUN/DRAIN, so they never collide with the start-time clear.
            if (w_cmp_fail) begin
                r_mismatch <= 1'b1;
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'h0001;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dl_valid <= '0;
        end else begin
            r_dl_valid[0] <= w_run;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_dl_ref[0] <= w_ref;
        for (int i = 1; i < int'(LATENCY); i++) begin
            r_dl_ref[i] <= r_dl_ref[i-1];
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign vec_count = r_vec_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_adder8_stim_checker.sv
// Bench for adder8_stim_checker: plays a registered adder and checks every cycle against
// a run-relative model built from the LFSR vector list and the sums actually returned.
module tb_adder8_stim_checker;

    localparam int          L    = 2;
    localparam int          N    = 256;
    localparam logic [23:0] SEED = 24'hACE15A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic [7:0]  a, b, sum;
    logic        cin, cout, busy, done, mm;
    logic [15:0] vc, ec;
    logic [7:0]  a0, b0;
    logic        cin0, busy0, done0, mm0;
    logic [15:0] vc0, ec0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder8_stim_checker #(.LATENCY(L), .NUM_VECTORS(N), .SEED(SEED)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .A_out(a), .B_out(b), .Cin_out(cin), .SUM_in(sum), .Cout_in(cout),
        .busy(busy), .done(done), .mismatch(mm), .vec_count(vc), .err_count(ec)
    );

    adder8_stim_checker #(.LATENCY(L), .NUM_VECTORS(0), .SEED(SEED)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .A_out(a0), .B_out(b0), .Cin_out(cin0), .SUM_in(8'h00), .Cout_in(1'b0),
        .busy(busy0), .done(done0), .mismatch(mm0), .vec_count(vc0), .err_count(ec0)
    );

    // Adder under test: input register feeding a pipeline, tap chosen by model_lat.
    int         model_lat = 2;
    logic       inv_cout  = 1'b0;
    logic [8:0] pipe [8];

    always @(posedge clk) begin
        pipe[0] <= {1'b0, a} + {1'b0, b} + {8'h00, cin};
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end
    assign {cout, sum} = pipe[model_lat-1] ^ {inv_cout, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] lfsr_step(input logic [23:0] s);
        return {s[22:0], s[24-1] ^ s[23-1] ^ s[22-1] ^ s[17-1]};
    endfunction

    // Expected vector list of one run.
    logic [7:0] va [N];
    logic [7:0] vb [N];
    logic       vcin [N];
    logic [8:0] vref [N];

    // Run-relative model: m_n is the cycle index since the first vector of the current run.
    bit m_active    = 1'b0;
    int m_n         = 0;
    int m_errs      = 0;
    bit m_fail_prev = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_active    = 1'b0;
            m_fail_prev = 1'b0;
        end else if (start && (!m_active || m_n >= N + L)) begin
            m_active    = 1'b1;
            m_n         = 0;
            m_errs      = 0;
            m_fail_prev = 1'b0;
        end else if (m_active) begin
            m_n++;
        end
    end

    always @(negedge clk) begin : compare
        logic [7:0] ea, eb;
        logic       ecin, ebusy, edone;
        int         evc, j;
        ea = 8'h00; eb = 8'h00; ecin = 1'b0; ebusy = 1'b0; edone = 1'b0; evc = 0;
        if (m_active) begin
            ebusy = (m_n < N + L);
            edone = !ebusy;
            evc   = (m_n < N) ? m_n : N;
            if (m_n < N) begin
                ea = va[m_n]; eb = vb[m_n]; ecin = vcin[m_n];
            end
        end
        chk("model_a", {24'h0, a}, {24'h0, ea});
        chk("model_b", {24'h0, b}, {24'h0, eb});
        chk("model_cin", {31'h0, cin}, {31'h0, ecin});
        chk("model_busy", {31'h0, busy}, {31'h0, ebusy});
        chk("model_done", {31'h0, done}, {31'h0, edone});
        chk("model_vec_count", {16'h0, vc}, evc);
        chk("model_err_count", {16'h0, ec}, m_errs);
        chk("model_mismatch", {31'h0, mm}, {31'h0, m_fail_prev});
        // The compare taking place in this cycle shows up next cycle.
        m_fail_prev = 1'b0;
        if (m_active) begin
            j = m_n - L;
            if (j >= 0 && j < N && {cout, sum} != vref[j]) begin
                m_fail_prev = 1'b1;
                if (m_errs < 65535) m_errs++;
            end
        end
    end

    bit busy0_seen = 1'b0;
    always @(negedge clk) if (busy0 === 1'b1) busy0_seen = 1'b1;

    task automatic wait_done(input string name, input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (done !== 1'b1 && cycles < bound);
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", name, bound);
        end
    endtask

    initial begin : main
        logic [23:0] s;
        int          c;
        s = SEED;
        for (int k = 0; k < N; k++) begin
            va[k]   = s[7:0];
            vb[k]   = s[15:8];
            vcin[k] = s[16];
            vref[k] = {1'b0, s[7:0]} + {1'b0, s[15:8]} + {8'h00, s[16]};
            s       = lfsr_step(s);
        end
        for (int i = 0; i < 8; i++) pipe[i] = 9'h000;

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_vec_count", {16'h0, vc}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Run 1: ideal adder; pin the first two vectors and end-of-run latency.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("first_vec", {15'h0, cin, b, a}, {15'h0, 1'b0, 8'hE1, 8'h5A});
        chk("first_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("second_vec", {15'h0, cin, b, a}, {15'h0, 1'b1, 8'hC2, 8'hB4});
        wait_done("run1", 400, c);
        chk("run1_cycles_to_done", c + 2, 32'd259);
        chk("run1_vec_count", {16'h0, vc}, 32'd256);
        chk("run1_err_count", {16'h0, ec}, 32'd0);

        // Run 2: inverted carry-out fails every compare.
        inv_cout = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("run2", 400, c);
        chk("inv_err_count", {16'h0, ec}, 32'd256);

        // Start held high: ignored while busy, restarts on the first done cycle.
        start = 1'b1;
        @(negedge clk);
        wait_done("hold", 400, c);
        chk("hold_err_final", {16'h0, ec}, 32'd256);
        @(negedge clk);
        chk("hold_restart_busy", {31'h0, busy}, 32'h1);
        chk("hold_restart_counts", {vc, ec}, 32'h0);
        chk("hold_restart_vec", {16'h0, b, a}, {16'h0, 8'hE1, 8'h5A});
        start = 1'b0;
        inv_cout = 1'b0;
        wait_done("hold_run2", 400, c);
        chk("hold_run2_err", {16'h0, ec}, 32'd0);

        // Adder slower than the checker expects.
        model_lat = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("lat3", 400, c);
        chk("lat3_err_nonzero", {31'h0, (ec != 16'h0)}, 32'h1);
        model_lat = 2;

        // Reset mid-run at vec_count=100, then a clean restart.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (vc != 16'd100 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("midrun_reached_100", {16'h0, vc}, 32'd100);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_reset_flags", {29'h0, busy, done, mm}, 32'h0);
        chk("midrun_reset_counts", {vc, ec}, 32'h0);
        chk("midrun_reset_vec", {15'h0, cin, b, a}, 32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_first_vec", {15'h0, cin, b, a}, {15'h0, 1'b0, 8'hE1, 8'h5A});
        wait_done("restart", 400, c);
        chk("restart_err", {16'h0, ec}, 32'd0);
        chk("restart_vec_count", {16'h0, vc}, 32'd256);

        // Zero-vector instance.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("nv0_done", {31'h0, done0}, 32'h1);
        chk("nv0_counts", {vc0, ec0}, 32'h0);
        repeat (4) @(negedge clk);
        chk("nv0_done_holds", {31'h0, done0}, 32'h1);
        chk("nv0_busy_never", {31'h0, busy0_seen}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
